// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between ALU and writeback.
// Moves 0, 1 or 2 bytes over a byte-wide req/ack bus.
module mem_stage (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_enable,
  input  logic [15:0] I_alu_out,
  input  logic [15:0] I_store_data,
  input  logic        I_write_rD,
  input  logic        I_write_pc,
  input  logic [1:0]  I_memory_mode,
  input  logic [1:0]  I_memory_size,
  output logic        O_mem_req,
  output logic        O_mem_we,
  output logic [15:0] O_mem_addr,
  output logic [7:0]  O_mem_wdata,
  input  logic [7:0]  I_mem_rdata,
  input  logic        I_mem_ack,
  output logic [15:0] O_result,
  output logic        O_write_rD,
  output logic        O_write_pc,
  output logic        O_done,
  output logic        O_busy
);

  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_XLO,
    S_XHI,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] sdata_q, sdata_d;
  logic [15:0] res_q, res_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        sz2_q, sz2_d;
  logic        wrd_q, wrd_d;
  logic        wpc_q, wpc_d;
  logic        in_rd, in_wr;

  assign in_rd = (I_memory_mode == MEM_READ);
  assign in_wr = (I_memory_mode == MEM_WRITE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    res_d   = res_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    sz2_d   = sz2_q;
    wrd_d   = wrd_q;
    wpc_d   = wpc_q;
    unique case (state_q)
      S_IDLE: begin
        if (I_enable) begin
          addr_d  = I_alu_out;
          sdata_d = I_store_data;
          rd_d    = in_rd;
          wr_d    = in_wr;
          sz2_d   = (I_memory_size == 2'd2);
          wrd_d   = I_write_rD & ~in_wr;
          wpc_d   = I_write_pc & ~in_wr;
          // reads build the result from zero; others pass alu_out
          res_d   = in_rd ? 16'h0000 : I_alu_out;
          state_d = (in_rd | in_wr) ? S_XLO : S_DONE;
        end
      end
      S_XLO: begin
        if (I_mem_ack) begin
          if (rd_q) res_d[7:0] = I_mem_rdata;
          state_d = sz2_q ? S_XHI : S_DONE;
        end
      end
      S_XHI: begin
        if (I_mem_ack) begin
          if (rd_q) res_d[15:8] = I_mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= 16'h0000;
      sdata_q <= 16'h0000;
      res_q   <= 16'h0000;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      sz2_q   <= 1'b0;
      wrd_q   <= 1'b0;
      wpc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      sz2_q   <= sz2_d;
      wrd_q   <= wrd_d;
      wpc_q   <= wpc_d;
    end
  end

  logic lo, hi, done;
  assign lo   = (state_q == S_XLO);
  assign hi   = (state_q == S_XHI);
  assign done = (state_q == S_DONE);

  assign O_mem_req   = lo | hi;
  assign O_mem_we    = (lo | hi) & wr_q;
  assign O_mem_addr  = hi ? (addr_q + 16'd1)
                     : (lo ? addr_q : 16'h0000);
  assign O_mem_wdata = hi ? sdata_q[15:8]
                     : (lo ? sdata_q[7:0] : 8'h00);

  // writeback bundle is only driven while the done strobe is up
  assign O_result   = done ? res_q : 16'h0000;
  assign O_write_rD = done & wrd_q;
  assign O_write_pc = done & wpc_q;
  assign O_done     = done;
  assign O_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage.
// Byte bus responder with programmable ack wait.
module tb_mem_stage;

  localparam logic [1:0] M_NOP = 2'd0;
  localparam logic [1:0] M_RD  = 2'd1;
  localparam logic [1:0] M_WR  = 2'd2;
  localparam logic [1:0] M_UNU = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] alu_out;
  logic [15:0] store_data;
  logic        write_rD;
  logic        write_pc;
  logic [1:0]  mem_mode;
  logic [1:0]  mem_size;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [15:0] result;
  logic        o_wrd;
  logic        o_wpc;
  logic        done;
  logic        busy;

  typedef struct {
    logic [15:0] res;
    logic        wrd;
    logic        wpc;
  } exp_t;

  exp_t sbq[$];
  int   total;
  int   passed;

  mem_stage dut (
    .I_clk        (clk),
    .I_reset_n    (rst_n),
    .I_enable     (enable),
    .I_alu_out    (alu_out),
    .I_store_data (store_data),
    .I_write_rD   (write_rD),
    .I_write_pc   (write_pc),
    .I_memory_mode(mem_mode),
    .I_memory_size(mem_size),
    .O_mem_req    (mem_req),
    .O_mem_we     (mem_we),
    .O_mem_addr   (mem_addr),
    .O_mem_wdata  (mem_wdata),
    .I_mem_rdata  (mem_rdata),
    .I_mem_ack    (mem_ack),
    .O_result     (result),
    .O_write_rD   (o_wrd),
    .O_write_pc   (o_wpc),
    .O_done       (done),
    .O_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm,
                        input logic [1:0]  mode,
                        input logic [1:0]  size,
                        input logic [15:0] alu,
                        input logic [15:0] st,
                        input logic        wrd,
                        input logic        wpc,
                        input int          waits,
                        input logic [7:0]  rlo,
                        input logic [7:0]  rhi,
                        input bit          poke);
    exp_t        e;
    exp_t        got;
    bit          mem;
    int          nbytes;
    int          nb;
    int          wcnt;
    int          ndone;
    int          dcyc;
    int          rcyc;
    int          extra;
    logic [15:0] a;
    mem    = (mode == M_RD) || (mode == M_WR);
    nbytes = mem ? ((size == 2'd2) ? 2 : 1) : 0;
    if (mode == M_RD)
      e.res = (nbytes == 2) ? {rhi, rlo} : {8'h00, rlo};
    else
      e.res = alu;
    e.wrd = (mode == M_WR) ? 1'b0 : wrd;
    e.wpc = (mode == M_WR) ? 1'b0 : wpc;
    sbq.push_back(e);
    nb = 0; wcnt = 0; ndone = 0;
    dcyc = -1; rcyc = 0; extra = 0;
    enable     = 1'b1;
    alu_out    = alu;
    store_data = st;
    write_rD   = wrd;
    write_pc   = wpc;
    mem_mode   = mode;
    mem_size   = size;
    mem_ack    = !mem;
    tick();
    enable     = 1'b0;
    alu_out    = ~alu;
    store_data = ~st;
    write_rD   = ~wrd;
    write_pc   = ~wpc;
    mem_mode   = ~mode;
    mem_size   = ~size;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin
        ndone++;
        dcyc = cyc;
        chk({nm, "_busy_done"}, busy, 1);
        if (sbq.size() == 0) begin
          chk({nm, "_sb_nonempty"}, 0, 1);
        end else begin
          got = sbq.pop_front();
          chk({nm, "_result"}, result, got.res);
          chk({nm, "_wrd"}, o_wrd, got.wrd);
          chk({nm, "_wpc"}, o_wpc, got.wpc);
        end
        if (poke) enable = 1'b1;
        tick();
        enable = 1'b0;
        break;
      end
      if (mem_req) begin
        rcyc++;
        a = alu + 16'(nb);
        chk({nm, "_addr"}, mem_addr, a);
        chk({nm, "_we"}, mem_we, mode == M_WR);
        if (mode == M_WR)
          chk({nm, "_wdata"}, mem_wdata,
              (nb == 0) ? st[7:0] : st[15:8]);
        enable = poke && (rcyc == 1);
        if (wcnt == waits) begin
          mem_ack   = 1'b1;
          mem_rdata = (nb == 0) ? rlo : rhi;
          nb++;
          wcnt = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'($urandom);
          wcnt++;
        end
      end else if (mem) begin
        mem_ack = 1'b0;
      end
      tick();
    end
    enable  = 1'b0;
    mem_ack = 1'b0;
    chk({nm, "_ndone"}, ndone, 1);
    chk({nm, "_latency"}, dcyc, 1 + nbytes * (1 + waits));
    chk({nm, "_req_cycles"}, rcyc, nbytes * (1 + waits));
    chk({nm, "_idle"}, busy, 0);
    for (int k = 0; k < 3; k++) begin
      if (done || mem_req) extra++;
      tick();
    end
    chk({nm, "_quiet"}, extra, 0);
  endtask

  initial begin
    int ndone;
    total      = 0;
    passed     = 0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    alu_out    = 16'h0;
    store_data = 16'h0;
    write_rD   = 1'b0;
    write_pc   = 1'b0;
    mem_mode   = M_NOP;
    mem_size   = 2'd0;
    mem_rdata  = 8'h00;
    mem_ack    = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    #10 rst_n = 1'b1;
    tick();
    tick();

    run_op("nop", M_NOP, 2'd1, 16'h1234, 16'h0,
           1, 0, 0, 8'h00, 8'h00, 0);
    run_op("rd1", M_RD, 2'd1, 16'h0040, 16'h0,
           1, 0, 2, 8'hA5, 8'h00, 0);
    run_op("rd2wrap", M_RD, 2'd2, 16'hFFFF, 16'h0,
           1, 1, 0, 8'h34, 8'h12, 0);
    run_op("wr2", M_WR, 2'd2, 16'h0100, 16'hBEEF,
           1, 1, 0, 8'h00, 8'h00, 0);
    run_op("busyign", M_RD, 2'd1, 16'h0055, 16'h0,
           1, 0, 1, 8'h3C, 8'h00, 1);
    run_op("unused", M_UNU, 2'd2, 16'hCAFE, 16'h0,
           0, 1, 0, 8'h00, 8'h00, 0);
    run_op("wr1", M_WR, 2'd3, 16'h0200, 16'h1177,
           0, 1, 1, 8'h00, 8'h00, 1);

    enable   = 1'b1;
    alu_out  = 16'h2000;
    mem_mode = M_RD;
    mem_size = 2'd2;
    write_rD = 1'b1;
    mem_ack  = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    chk("rstx_req_before", mem_req, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rstx_req", mem_req, 0);
    chk("rstx_busy", busy, 0);
    chk("rstx_addr", mem_addr, 0);
    #2 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("rstx_nodone", ndone, 0);
    chk("rstx_idle", busy, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
